// File: rtl/gray_pkg.sv
// Shared types and constants for grayscale_arbiter: FSM encoding, luma shift
// taps and the width of the optional grant statistics counters.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam int CNT_W   = 4;
    localparam int STATS_W = 16;

    // Shift amounts approximating Y = 0.299 R + 0.587 G + 0.114 B.
    localparam int LUMA_R_SH0 = 2;
    localparam int LUMA_R_SH1 = 5;
    localparam int LUMA_R_SH2 = 6;
    localparam int LUMA_G_SH0 = 1;
    localparam int LUMA_G_SH1 = 4;
    localparam int LUMA_G_SH2 = 6;
    localparam int LUMA_G_SH3 = 7;
    localparam int LUMA_B_SH0 = 4;
    localparam int LUMA_B_SH1 = 5;
    localparam int LUMA_B_SH2 = 6;

    function automatic logic [STATS_W-1:0] stat_inc(input logic [STATS_W-1:0] v);
        return (v == {STATS_W{1'b1}}) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/luma_shift_add.sv
// Combinational RGB-to-luma converter built only from truncated shifts and adds.
module luma_shift_add
    import gray_pkg::*;
#(
    parameter int P_SUBPIXEL_DEPTH = 8
) (
    input  logic [3*P_SUBPIXEL_DEPTH-1:0] i_rgb,
    output logic [P_SUBPIXEL_DEPTH-1:0]   o_y
);

    logic [P_SUBPIXEL_DEPTH-1:0] w_r;
    logic [P_SUBPIXEL_DEPTH-1:0] w_g;
    logic [P_SUBPIXEL_DEPTH-1:0] w_b;

    assign w_r = i_rgb[3*P_SUBPIXEL_DEPTH-1 -: P_SUBPIXEL_DEPTH];
    assign w_g = i_rgb[2*P_SUBPIXEL_DEPTH-1 -: P_SUBPIXEL_DEPTH];
    assign w_b = i_rgb[P_SUBPIXEL_DEPTH-1:0];

    // Coefficients sum below one, so the subpixel-width sum cannot wrap.
    assign o_y = (w_r >> LUMA_R_SH0) + (w_r >> LUMA_R_SH1) + (w_r >> LUMA_R_SH2)
               + (w_g >> LUMA_G_SH0) + (w_g >> LUMA_G_SH1) + (w_g >> LUMA_G_SH2)
               + (w_g >> LUMA_G_SH3)
               + (w_b >> LUMA_B_SH0) + (w_b >> LUMA_B_SH1) + (w_b >> LUMA_B_SH2);

endmodule

// File: rtl/grayscale_arbiter.sv
// Burst-limited round-robin arbiter feeding a 2-stage stallable luma pipeline.
// Define GRAYSCALE_ARB_STATS_EN to add saturating per-requester grant counters.
module grayscale_arbiter
    import gray_pkg::*;
#(
    parameter int P_PIXEL_DEPTH    = 24,
    parameter int P_SUBPIXEL_DEPTH = P_PIXEL_DEPTH / 3,
    parameter int P_MAX_BURST      = 4
) (
    input  logic                        I_CLK,
    input  logic                        I_RESET_N,
    input  logic                        I_REQ0_VALID,
    input  logic [P_PIXEL_DEPTH-1:0]    I_REQ0_PIXEL,
    output logic                        O_REQ0_READY,
    input  logic                        I_REQ1_VALID,
    input  logic [P_PIXEL_DEPTH-1:0]    I_REQ1_PIXEL,
    output logic                        O_REQ1_READY,
    output logic                        O_VALID,
    output logic [P_SUBPIXEL_DEPTH-1:0] O_PIXEL,
    output logic                        O_ID,
    input  logic                        I_READY
`ifdef GRAYSCALE_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]          O_GNT_CNT0,
    output logic [STATS_W-1:0]          O_GNT_CNT1
`endif
);

    localparam logic [CNT_W-1:0] L_MAX = CNT_W'(P_MAX_BURST);

    arb_state_e                  r_state;
    arb_state_e                  w_state_nxt;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_nxt;
    logic [CNT_W-1:0]            w_cnt_base;
    logic                        r_last;

    logic                        w_cur;
    logic                        w_v_cur;
    logic                        w_v_oth;
    logic                        w_gnt_vld;
    logic                        w_gnt_id;
    logic                        w_switch;
    logic                        w_xfer;

    logic                        r_s1_valid;
    logic [P_PIXEL_DEPTH-1:0]    r_s1_rgb;
    logic                        r_s1_id;
    logic                        r_s2_valid;
    logic [P_SUBPIXEL_DEPTH-1:0] r_s2_pix;
    logic                        r_s2_id;
    logic                        w_s1_en;
    logic                        w_s2_en;
    logic [P_SUBPIXEL_DEPTH-1:0] w_luma;

    assign w_s2_en = !r_s2_valid || I_READY;
    assign w_s1_en = !r_s1_valid || w_s2_en;

    assign w_cur   = (r_state == GNT1);
    assign w_v_cur = w_cur ? I_REQ1_VALID : I_REQ0_VALID;
    assign w_v_oth = w_cur ? I_REQ0_VALID : I_REQ1_VALID;

    // Grant decision for this cycle, so a switch costs no dead cycle.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        w_switch  = 1'b0;
        case (r_state)
            IDLE: begin
                if (I_REQ0_VALID && I_REQ1_VALID) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_id  = ~r_last;
                    w_switch  = 1'b1;
                end else if (I_REQ0_VALID || I_REQ1_VALID) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_id  = I_REQ1_VALID;
                    w_switch  = 1'b1;
                end else begin
                    w_gnt_vld = 1'b0;
                end
            end
            GNT0, GNT1: begin
                if (w_v_cur && !(w_v_oth && (r_cnt >= L_MAX))) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_id  = w_cur;
                end else if (w_v_oth) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_id  = ~w_cur;
                    w_switch  = 1'b1;
                end else begin
                    w_gnt_vld = 1'b0;
                end
            end
            default: begin
                w_gnt_vld = 1'b0;
            end
        endcase
    end

    // Readies are forced low while reset is asserted, independent of the clock.
    assign w_xfer       = w_gnt_vld && w_s1_en && I_RESET_N;
    assign O_REQ0_READY = w_xfer && !w_gnt_id;
    assign O_REQ1_READY = w_xfer && w_gnt_id;

    // Next FSM state and saturating burst count.
    always_comb begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_cnt_base  = {CNT_W{1'b0}};
        if (w_gnt_vld) begin
            w_state_nxt = w_gnt_id ? GNT1 : GNT0;
            w_cnt_base  = w_switch ? {CNT_W{1'b0}} : r_cnt;
            if (w_xfer && (w_cnt_base < L_MAX)) begin
                w_cnt_nxt = w_cnt_base + CNT_W'(1);
            end else begin
                w_cnt_nxt = w_cnt_base;
            end
        end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
        end
    end

    // Arbiter state registers.
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_xfer) begin
                r_last <= w_gnt_id;
            end
        end
    end

    luma_shift_add #(
        .P_SUBPIXEL_DEPTH (P_SUBPIXEL_DEPTH)
    ) u_luma (
        .i_rgb (r_s1_rgb),
        .o_y   (w_luma)
    );

    // Stage 1 holds the granted RGB, stage 2 its luma; each advances only when enabled.
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_s1_valid <= 1'b0;
            r_s1_rgb   <= {P_PIXEL_DEPTH{1'b0}};
            r_s1_id    <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_pix   <= {P_SUBPIXEL_DEPTH{1'b0}};
            r_s2_id    <= 1'b0;
        end else begin
            if (w_s1_en) begin
                r_s1_valid <= w_xfer;
                if (w_xfer) begin
                    r_s1_rgb <= w_gnt_id ? I_REQ1_PIXEL : I_REQ0_PIXEL;
                    r_s1_id  <= w_gnt_id;
                end
            end
            if (w_s2_en) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_pix <= w_luma;
                    r_s2_id  <= r_s1_id;
                end
            end
        end
    end

    assign O_VALID = r_s2_valid;
    assign O_PIXEL = r_s2_pix;
    assign O_ID    = r_s2_id;

`ifdef GRAYSCALE_ARB_STATS_EN
    logic [STATS_W-1:0] r_gnt_cnt0;
    logic [STATS_W-1:0] r_gnt_cnt1;

    // Saturating accepted-transfer counters per requester.
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_gnt_cnt0 <= {STATS_W{1'b0}};
            r_gnt_cnt1 <= {STATS_W{1'b0}};
        end else begin
            if (O_REQ0_READY && I_REQ0_VALID) begin
                r_gnt_cnt0 <= stat_inc(r_gnt_cnt0);
            end
            if (O_REQ1_READY && I_REQ1_VALID) begin
                r_gnt_cnt1 <= stat_inc(r_gnt_cnt1);
            end
        end
    end

    assign O_GNT_CNT0 = r_gnt_cnt0;
    assign O_GNT_CNT1 = r_gnt_cnt1;
`endif

endmodule

// File: tb/tb_grayscale_arbiter.sv
// Directed bench for grayscale_arbiter with an in-order scoreboard on the output.
module tb_grayscale_arbiter;

    logic        clk;
    logic        rst_n;
    logic        v0, v1, r0, r1;
    logic [23:0] p0, p1;
    logic        o_valid, o_id, i_ready;
    logic [7:0]  o_pixel;
`ifdef GRAYSCALE_ARB_STATS_EN
    logic [15:0] gcnt0, gcnt1;
`endif

    int          n_chk, n_pass, cyc;
    logic [7:0]  q_pix [$];
    logic        q_id  [$];
    logic        acc_id [$];
    int          acc_cyc [$];
    logic [7:0]  out_pix [$];
    logic        out_id  [$];
    int          out_cyc [$];
    logic [7:0]  exp1 [4];

    grayscale_arbiter dut (
        .I_CLK        (clk),
        .I_RESET_N    (rst_n),
        .I_REQ0_VALID (v0),
        .I_REQ0_PIXEL (p0),
        .O_REQ0_READY (r0),
        .I_REQ1_VALID (v1),
        .I_REQ1_PIXEL (p1),
        .O_REQ1_READY (r1),
        .O_VALID      (o_valid),
        .O_PIXEL      (o_pixel),
        .O_ID         (o_id),
        .I_READY      (i_ready)
`ifdef GRAYSCALE_ARB_STATS_EN
        ,
        .O_GNT_CNT0   (gcnt0),
        .O_GNT_CNT1   (gcnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] luma_ref(input logic [23:0] p);
        logic [7:0] r, g, b;
        r = p[23:16];
        g = p[15:8];
        b = p[7:0];
        return (r >> 2) + (r >> 5) + (r >> 6) + (g >> 1) + (g >> 4) + (g >> 6) + (g >> 7)
             + (b >> 4) + (b >> 5) + (b >> 6);
    endfunction

    task automatic clear_logs();
        acc_id.delete(); acc_cyc.delete();
        out_pix.delete(); out_id.delete(); out_cyc.delete();
    endtask

    // One clock: sample at negedge, score, then return just after the next posedge.
    task automatic tick();
        @(negedge clk);
        chk("rdy_onehot", 32'(r0 & r1), 32'd0);
        chk("rdy0_wo_vld", 32'(r0 & ~v0), 32'd0);
        chk("rdy1_wo_vld", 32'(r1 & ~v1), 32'd0);
        if (v0 && r0) begin
            q_pix.push_back(luma_ref(p0)); q_id.push_back(1'b0);
            acc_id.push_back(1'b0); acc_cyc.push_back(cyc);
        end else if (v1 && r1) begin
            q_pix.push_back(luma_ref(p1)); q_id.push_back(1'b1);
            acc_id.push_back(1'b1); acc_cyc.push_back(cyc);
        end
        if (o_valid && i_ready) begin
            out_pix.push_back(o_pixel); out_id.push_back(o_id); out_cyc.push_back(cyc);
            chk("out_expected", 32'(q_pix.size() != 0), 32'd1);
            if (q_pix.size() != 0) begin
                chk("sb_pix", 32'(o_pixel), 32'(q_pix.pop_front()));
                chk("sb_id", 32'(o_id), 32'(q_id.pop_front()));
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        i_ready = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_pix", 32'(o_pixel), 32'd0);
        chk("rst_id", 32'(o_id), 32'd0);
        chk("rst_rdy", 32'(r0 | r1), 32'd0);
        q_pix.delete(); q_id.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] hold_pix;
        logic       hold_id;
        logic       acc0, acc1;
        int         gap, n1, wait0;
        n_chk = 0; n_pass = 0; cyc = 0;
        v0 = 1'b0; v1 = 1'b0; p0 = 24'd0; p1 = 24'd0; i_ready = 1'b1; rst_n = 1'b0;
        exp1 = '{8'h49, 8'h92, 8'h19, 8'hF4};

        // Primary colours from REQ0 alone.
        reset_dut();
        clear_logs();
        v0 = 1'b1;
        p0 = 24'hFF0000; tick();
        p0 = 24'h00FF00; tick();
        p0 = 24'h0000FF; tick();
        p0 = 24'hFFFFFF; tick();
        v0 = 1'b0;
        repeat (4) tick();
        chk("t1_n_out", 32'(out_pix.size()), 32'd4);
        if (out_pix.size() == 4 && acc_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_pix", 32'(out_pix[i]), 32'(exp1[i]));
                chk("t1_id", 32'(out_id[i]), 32'd0);
                chk("t1_latency", 32'(out_cyc[i] - acc_cyc[i]), 32'd2);
            end
        end

        // Burst limit with both requesters saturated.
        reset_dut();
        clear_logs();
        v0 = 1'b1; v1 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            p0 = {8'(k * 16), 8'h40, 8'(k)};
            p1 = {8'h20, 8'(k * 8), 8'(255 - k)};
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (4) tick();
        chk("t2_n_acc", 32'(acc_id.size()), 32'd16);
        if (acc_id.size() == 16 && out_id.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk("t2_gnt", 32'(acc_id[i]), 32'((i / 4) % 2));
                chk("t2_no_gap", 32'(acc_cyc[i] - acc_cyc[0]), 32'(i));
                chk("t2_out_id", 32'(out_id[i]), 32'((i / 4) % 2));
            end
        end

        // Downstream stall mid-stream.
        clear_logs();
        v0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            p0 = {8'(30 * k), 8'(200 - k), 8'h77};
            tick();
        end
        i_ready  = 1'b0;
        hold_pix = o_pixel;
        hold_id  = o_id;
        chk("t3_stall_valid", 32'(o_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            p0 = {8'h11, 8'(k * 40), 8'h99};
            tick();
            chk("t3_hold_pix", 32'(o_pixel), 32'(hold_pix));
            chk("t3_hold_id", 32'(o_id), 32'(hold_id));
            chk("t3_rdy_low", 32'(r0 | r1), 32'd0);
        end
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            p0 = {8'hC0, 8'(k), 8'(k * 60)};
            tick();
        end
        v0 = 1'b0;
        repeat (4) tick();
        chk("t3_drained", 32'(q_pix.size()), 32'd0);
        chk("t3_in_eq_out", 32'(out_pix.size()), 32'(acc_id.size()));

        // REQ1 sparse while REQ0 streams.
        clear_logs();
        v0 = 1'b1; v1 = 1'b1; gap = 0; n1 = 0; wait0 = 0;
        for (int k = 0; k < 80 && n1 < 5; k++) begin
            p0 = {8'(k), 8'h80, 8'h10};
            p1 = {8'h05, 8'(k * 3), 8'hE0};
            acc0 = v0 && r0;
            acc1 = v1 && r1;
            tick();
            if (acc0 && v1) wait0++;
            if (acc1) begin
                chk("t4_wait", 32'(wait0 <= 4), 32'd1);
                n1++; wait0 = 0; v1 = 1'b0; gap = 2;
            end else if (!v1) begin
                gap--;
                if (gap == 0) v1 = 1'b1;
            end
        end
        chk("t4_n_req1", 32'(n1), 32'd5);
        v0 = 1'b0; v1 = 1'b0;
        repeat (4) tick();
        chk("t4_drained", 32'(q_pix.size()), 32'd0);

        // Reset pulse during a REQ1 burst with pixels in flight.
        reset_dut();
        v1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            p1 = {8'(k * 70), 8'h33, 8'h66};
            tick();
        end
        chk("t5_inflight", 32'(o_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(o_valid), 32'd0);
        chk("t5_rst_pix", 32'(o_pixel), 32'd0);
        chk("t5_rst_rdy1", 32'(r1), 32'd0);
        q_pix.delete(); q_id.delete();
        clear_logs();
        v0 = 1'b1; p0 = 24'h123456;
        #1;
        rst_n = 1'b1;
        #1;
        chk("t5_first_rdy0", 32'(r0), 32'd1);
        chk("t5_first_rdy1", 32'(r1), 32'd0);
        repeat (6) tick();
        v0 = 1'b0; v1 = 1'b0;
        repeat (4) tick();
        chk("t5_n_out", 32'(out_pix.size()), 32'(acc_id.size()));
        if (out_id.size() != 0) chk("t5_first_id", 32'(out_id[0]), 32'd0);
        chk("t5_drained", 32'(q_pix.size()), 32'd0);

`ifdef GRAYSCALE_ARB_STATS_EN
        // Grant statistics and their saturation.
        reset_dut();
        chk("st_rst0", 32'(gcnt0), 32'd0);
        v0 = 1'b1; p0 = 24'h808080;
        repeat (10) tick();
        v0 = 1'b0; v1 = 1'b1; p1 = 24'h404040;
        repeat (7) tick();
        v1 = 1'b0;
        tick();
        chk("st_cnt0", 32'(gcnt0), 32'd10);
        chk("st_cnt1", 32'(gcnt1), 32'd7);
        v0 = 1'b1;
        repeat (70000) tick();
        v0 = 1'b0;
        tick();
        chk("st_sat0", 32'(gcnt0), 32'hFFFF);
        chk("st_cnt1_kept", 32'(gcnt1), 32'd7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
